// File: rtl/ieu_ex.sv
// Integer execute unit: single-cycle ALU/branch/jump evaluation feeding a
// 2-entry result FIFO that arbitrates for the common data bus.
module ieu_ex #(
    parameter  int OPTN_DATA_WIDTH      = 32,
    parameter  int OPTN_ADDR_WIDTH      = 32,
    parameter  int OPTN_ROB_IDX_WIDTH   = 5,
    localparam int PCYN_ALU_FUNC_WIDTH  = 4,
    localparam int PCYN_ALU_SHAMT_WIDTH = $clog2(OPTN_DATA_WIDTH)
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_flush,
    input  logic [PCYN_ALU_FUNC_WIDTH-1:0]  i_alu_func,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_src_a,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_src_b,
    input  logic [OPTN_ADDR_WIDTH-1:0]      i_iaddr,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_imm_b,
    input  logic [PCYN_ALU_SHAMT_WIDTH-1:0] i_shamt,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]   i_tag,
    input  logic                            i_jmp,
    input  logic                            i_br,
    input  logic                            i_valid,
    output logic                            o_stall,
    output logic                            o_cdb_valid,
    input  logic                            i_cdb_gnt,
    output logic [OPTN_DATA_WIDTH-1:0]      o_cdb_data,
    output logic [OPTN_ADDR_WIDTH-1:0]      o_cdb_addr,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]   o_cdb_tag,
    output logic                            o_cdb_redirect
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,  ALU_SLL = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
        ALU_EQ  = 4'd8,  ALU_NE  = 4'd9,  ALU_LT  = 4'd10, ALU_LTU = 4'd11,
        ALU_GE  = 4'd12, ALU_GEU = 4'd13
    } alu_func_e;

    logic [OPTN_DATA_WIDTH-1:0]    ab_sum;
    logic [OPTN_DATA_WIDTH-1:0]    alu_res;
    logic [OPTN_ADDR_WIDTH-1:0]    seq_addr;
    logic [OPTN_ADDR_WIDTH-1:0]    jmp_addr;
    logic [OPTN_DATA_WIDTH-1:0]    res_data;
    logic [OPTN_ADDR_WIDTH-1:0]    res_addr;
    logic                          res_redirect;

    logic [OPTN_DATA_WIDTH-1:0]    data_q     [2];
    logic [OPTN_ADDR_WIDTH-1:0]    addr_q     [2];
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_q      [2];
    logic                          redirect_q [2];
    logic [1:0]                    count_q, count_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic                          push, pop;

    assign ab_sum   = i_src_a + i_src_b;
    assign seq_addr = i_iaddr + OPTN_ADDR_WIDTH'(4);

    always_comb begin
        jmp_addr    = OPTN_ADDR_WIDTH'(ab_sum);
        jmp_addr[0] = 1'b0;
    end

    always_comb begin
        alu_res = '0;
        case (i_alu_func)
            ALU_ADD: alu_res = ab_sum;
            ALU_SUB: alu_res = i_src_a - i_src_b;
            ALU_AND: alu_res = i_src_a & i_src_b;
            ALU_OR:  alu_res = i_src_a | i_src_b;
            ALU_XOR: alu_res = i_src_a ^ i_src_b;
            ALU_SLL: alu_res = i_src_a << i_shamt;
            ALU_SRL: alu_res = i_src_a >> i_shamt;
            ALU_SRA: alu_res = OPTN_DATA_WIDTH'($signed(i_src_a) >>> i_shamt);
            ALU_EQ:  alu_res[0] = (i_src_a == i_src_b);
            ALU_NE:  alu_res[0] = (i_src_a != i_src_b);
            ALU_LT:  alu_res[0] = ($signed(i_src_a) < $signed(i_src_b));
            ALU_LTU: alu_res[0] = (i_src_a < i_src_b);
            ALU_GE:  alu_res[0] = ($signed(i_src_a) >= $signed(i_src_b));
            ALU_GEU: alu_res[0] = (i_src_a >= i_src_b);
            default: alu_res = '0;
        endcase
    end

    // Jumps take priority over branches; plain ALU ops fall through.
    always_comb begin
        res_data     = alu_res;
        res_addr     = seq_addr;
        res_redirect = 1'b0;
        if (i_jmp) begin
            res_data     = OPTN_DATA_WIDTH'(seq_addr);
            res_addr     = jmp_addr;
            res_redirect = 1'b1;
        end else if (i_br) begin
            res_data     = '0;
            res_redirect = alu_res[0];
            res_addr     = alu_res[0] ? (i_iaddr + OPTN_ADDR_WIDTH'(i_imm_b)) : seq_addr;
        end
    end

    assign o_cdb_valid = (count_q != 2'd0);
    assign o_stall     = (count_q == 2'd2);
    assign push        = i_valid & ~o_stall & ~i_flush;
    assign pop         = o_cdb_valid & i_cdb_gnt & ~i_flush;

    always_comb begin
        count_d  = count_q + 2'(push) - 2'(pop);
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (i_flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q]     <= res_data;
            addr_q[wr_ptr_q]     <= res_addr;
            tag_q[wr_ptr_q]      <= i_tag;
            redirect_q[wr_ptr_q] <= res_redirect;
        end
    end

    assign o_cdb_data     = data_q[rd_ptr_q];
    assign o_cdb_addr     = addr_q[rd_ptr_q];
    assign o_cdb_tag      = tag_q[rd_ptr_q];
    assign o_cdb_redirect = redirect_q[rd_ptr_q];

endmodule

// File: tb/tb_ieu_ex.sv
// Testbench for ieu_ex: directed scenarios then randomized traffic, all
// checked against a queue-based transaction model of the execute unit.
module tb_ieu_ex;

    localparam logic [3:0] F_ADD = 4'd0,  F_SUB = 4'd1,  F_AND = 4'd2,  F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4,  F_SLL = 4'd5,  F_SRL = 4'd6,  F_SRA = 4'd7;
    localparam logic [3:0] F_EQ  = 4'd8,  F_NE  = 4'd9,  F_LT  = 4'd10, F_LTU = 4'd11;
    localparam logic [3:0] F_GE  = 4'd12, F_GEU = 4'd13;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  tag;
        logic        redir;
    } ent_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_flush;
    logic [3:0]  i_alu_func;
    logic [31:0] i_src_a, i_src_b, i_iaddr, i_imm_b;
    logic [4:0]  i_shamt, i_tag;
    logic        i_jmp, i_br, i_valid, i_cdb_gnt;
    logic        o_stall, o_cdb_valid, o_cdb_redirect;
    logic [31:0] o_cdb_data, o_cdb_addr;
    logic [4:0]  o_cdb_tag;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    ieu_ex dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_alu_func(i_alu_func),
        .i_src_a(i_src_a), .i_src_b(i_src_b), .i_iaddr(i_iaddr), .i_imm_b(i_imm_b),
        .i_shamt(i_shamt), .i_tag(i_tag), .i_jmp(i_jmp), .i_br(i_br),
        .i_valid(i_valid), .o_stall(o_stall), .o_cdb_valid(o_cdb_valid),
        .i_cdb_gnt(i_cdb_gnt), .o_cdb_data(o_cdb_data), .o_cdb_addr(o_cdb_addr),
        .o_cdb_tag(o_cdb_tag), .o_cdb_redirect(o_cdb_redirect)
    );

    always #5 clk = ~clk;

    function automatic ent_t refModel(logic [3:0] f, logic [31:0] a, logic [31:0] b,
                                      logic [4:0] sh, logic [31:0] ia, logic [31:0] imm,
                                      logic [4:0] tg, logic j, logic br);
        ent_t        e;
        logic [31:0] r;
        longint      sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            F_ADD:   r = a + b;
            F_SUB:   r = a - b;
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_XOR:   r = a ^ b;
            F_SLL:   r = a << sh;
            F_SRL:   r = a >> sh;
            F_SRA:   r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            F_EQ:    r = (a == b) ? 32'd1 : 32'd0;
            F_NE:    r = (a != b) ? 32'd1 : 32'd0;
            F_LT:    r = (sa < sb) ? 32'd1 : 32'd0;
            F_LTU:   r = (a < b) ? 32'd1 : 32'd0;
            F_GE:    r = (sa >= sb) ? 32'd1 : 32'd0;
            F_GEU:   r = (a >= b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        e.tag = tg;
        if (j) begin
            e.data  = ia + 32'd4;
            e.addr  = (a + b) & 32'hFFFF_FFFE;
            e.redir = 1'b1;
        end else if (br) begin
            e.data  = 32'd0;
            e.redir = r[0];
            e.addr  = r[0] ? ia + imm : ia + 32'd4;
        end else begin
            e.data  = r;
            e.addr  = ia + 32'd4;
            e.redir = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [31:0] ia, input logic [31:0] imm,
                                 input logic [4:0] tg, input logic j, input logic br, input logic v);
        i_alu_func = f;  i_src_a = a;  i_src_b = b;  i_shamt = sh;
        i_iaddr = ia;    i_imm_b = imm; i_tag = tg;  i_jmp = j;
        i_br = br;       i_valid = v;
    endtask

    // Called just after a falling edge: compare against the model, then advance one cycle.
    task automatic stepCycle();
        ent_t e;
        bit   acc, pp;
        checkOutput("cdb_valid", {63'd0, o_cdb_valid}, {63'd0, mq.size() != 0});
        checkOutput("stall", {63'd0, o_stall}, {63'd0, mq.size() == 2});
        if (mq.size() != 0) begin
            checkOutput("cdb_data", {32'd0, o_cdb_data}, {32'd0, mq[0].data});
            checkOutput("cdb_addr", {32'd0, o_cdb_addr}, {32'd0, mq[0].addr});
            checkOutput("cdb_tag", {59'd0, o_cdb_tag}, {59'd0, mq[0].tag});
            checkOutput("cdb_redirect", {63'd0, o_cdb_redirect}, {63'd0, mq[0].redir});
        end
        acc = n_rst && !i_flush && i_valid && (mq.size() < 2);
        pp  = n_rst && !i_flush && i_cdb_gnt && (mq.size() != 0);
        e   = refModel(i_alu_func, i_src_a, i_src_b, i_shamt, i_iaddr, i_imm_b, i_tag, i_jmp, i_br);
        @(posedge clk);
        if (!n_rst || i_flush) begin
            mq.delete();
        end else begin
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    // Issue a single op with grant held, check the head against literal values, then let it drain.
    task automatic directedOp(input string name, input logic [3:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] sh, input logic [31:0] ia,
                              input logic [31:0] imm, input logic j, input logic br,
                              input logic [31:0] expData, input logic [31:0] expAddr,
                              input logic expRedir);
        i_cdb_gnt = 1'b1;
        applyStimulus(f, a, b, sh, ia, imm, 5'd7, j, br, 1'b1);
        stepCycle();
        i_valid = 1'b0;
        checkOutput({name, "_valid"}, {63'd0, o_cdb_valid}, 64'd1);
        checkOutput({name, "_data"}, {32'd0, o_cdb_data}, {32'd0, expData});
        checkOutput({name, "_addr"}, {32'd0, o_cdb_addr}, {32'd0, expAddr});
        checkOutput({name, "_redir"}, {63'd0, o_cdb_redirect}, {63'd0, expRedir});
        stepCycle();
    endtask

    initial begin
        n_rst = 1'b0; i_flush = 1'b0; i_cdb_gnt = 1'b0;
        applyStimulus(F_ADD, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", {63'd0, o_cdb_valid}, 64'd0);
        checkOutput("reset_stall", {63'd0, o_stall}, 64'd0);
        n_rst = 1'b1;
        stepCycle();

        // ADD with grant held: visible one cycle later, then gone.
        i_cdb_gnt = 1'b1;
        applyStimulus(F_ADD, 32'd5, 32'd7, 5'd0, 32'h40, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1);
        stepCycle();
        i_valid = 1'b0;
        checkOutput("add_valid", {63'd0, o_cdb_valid}, 64'd1);
        checkOutput("add_data", {32'd0, o_cdb_data}, 64'd12);
        checkOutput("add_tag", {59'd0, o_cdb_tag}, 64'd3);
        checkOutput("add_addr", {32'd0, o_cdb_addr}, 64'h44);
        checkOutput("add_redir", {63'd0, o_cdb_redirect}, 64'd0);
        stepCycle();
        checkOutput("add_drained", {63'd0, o_cdb_valid}, 64'd0);

        directedOp("beq_taken", F_EQ, 32'd9, 32'd9, 5'd0, 32'h100, 32'h20, 1'b0, 1'b1, 32'd0, 32'h120, 1'b1);
        directedOp("beq_not", F_EQ, 32'd9, 32'd8, 5'd0, 32'h100, 32'h20, 1'b0, 1'b1, 32'd0, 32'h104, 1'b0);
        directedOp("jalr", F_ADD, 32'h1001, 32'd4, 5'd0, 32'h200, 32'd0, 1'b1, 1'b0, 32'h204, 32'h1004, 1'b1);
        directedOp("sra", F_SRA, 32'h8000_0000, 32'd0, 5'd4, 32'h300, 32'd0, 1'b0, 1'b0, 32'hF800_0000, 32'h304, 1'b0);
        directedOp("sltu", F_LTU, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'h400, 32'd0, 1'b0, 1'b0, 32'd1, 32'h404, 1'b0);
        directedOp("undef", 4'd15, 32'd3, 32'd4, 5'd1, 32'h500, 32'd0, 1'b0, 1'b0, 32'd0, 32'h504, 1'b0);

        // Backpressure: three ops without grant, third held until space frees.
        i_cdb_gnt = 1'b0;
        applyStimulus(F_ADD, 32'd1, 32'd1, 5'd0, 32'h0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(F_SUB, 32'd9, 32'd2, 5'd0, 32'h4, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(F_XOR, 32'hF0, 32'h0F, 5'd0, 32'h8, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bp_stall", {63'd0, o_stall}, 64'd1);
        i_cdb_gnt = 1'b1;
        checkOutput("bp_order0", {59'd0, o_cdb_tag}, 64'd0);
        stepCycle();
        checkOutput("bp_order1", {59'd0, o_cdb_tag}, 64'd1);
        stepCycle();
        i_valid = 1'b0;
        checkOutput("bp_order2", {59'd0, o_cdb_tag}, 64'd2);
        stepCycle();
        checkOutput("bp_empty", {63'd0, o_cdb_valid}, 64'd0);

        // Flush with a full FIFO, competing push and grant.
        i_cdb_gnt = 1'b0;
        applyStimulus(F_OR, 32'd1, 32'd2, 5'd0, 32'h10, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        i_flush = 1'b1; i_cdb_gnt = 1'b1;
        stepCycle();
        i_flush = 1'b0; i_valid = 1'b0;
        checkOutput("flush_valid", {63'd0, o_cdb_valid}, 64'd0);
        checkOutput("flush_stall", {63'd0, o_stall}, 64'd0);

        // Reset while draining.
        i_cdb_gnt = 1'b0;
        applyStimulus(F_AND, 32'hFF, 32'h3C, 5'd0, 32'h20, 32'd0, 5'd5, 1'b0, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        i_cdb_gnt = 1'b1;
        stepCycle();
        n_rst = 1'b0;
        stepCycle();
        n_rst = 1'b1; i_valid = 1'b0;
        checkOutput("rst_mid_valid", {63'd0, o_cdb_valid}, 64'd0);
        checkOutput("rst_mid_stall", {63'd0, o_stall}, 64'd0);
        stepCycle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, b;
            logic        j, br;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            j  = ($urandom_range(0, 7) == 0);
            br = !j && ($urandom_range(0, 3) == 0);
            applyStimulus(br ? 4'($urandom_range(8, 13)) : 4'($urandom_range(0, 15)),
                          a, b, 5'($urandom), $urandom, $urandom, 5'($urandom), j, br,
                          1'($urandom_range(0, 2) != 0));
            i_cdb_gnt = ($urandom_range(0, 2) != 0);
            i_flush   = ($urandom_range(0, 29) == 0);
            n_rst     = ($urandom_range(0, 49) != 0);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
